// File: rtl/pio_cond_pkg.sv
// pio_cond_pkg
// Shared types, defaults and helpers for the PIO input conditioner.
// Contents:
//   deb_state_t          per-bit debounce FSM state
//   DEF_* localparams    defaults for a 50 MHz clock and a 10 ms debounce
//   cnt_width(n)         bits needed to hold a count of 0..n
package pio_cond_pkg;

  // state      | meaning
  // ST_STABLE  | synchronised input agrees with clean level
  // ST_PENDING | input differs; counting consecutive differing clocks
  typedef enum logic {ST_STABLE, ST_PENDING} deb_state_t;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_DEBOUNCE_MS     = 10;
  localparam int DEF_DEBOUNCE_CYCLES = (DEF_CLK_HZ / 1000) * DEF_DEBOUNCE_MS;
  localparam int DEF_SYNC_STAGES     = 2;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pio_input_conditioner_debounce_bit.sv
// debounce_bit
// One conditioned input: synchroniser, polarity fix, debounce FSM and counter.
// Ports:
//   clk_50      in   system clock
//   reset       in   synchronous active-low reset
//   raw         in   asynchronous pin
//   clean       out  debounced logical level (1 = active)
//   rise_pulse  out  one-cycle pulse on the edge clean goes 0->1
//   fall_pulse  out  one-cycle pulse on the edge clean goes 1->0
module debounce_bit
  import pio_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk_50,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_bit: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("debounce_bit: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   accept;
  deb_state_t             state;
  logic [CW-1:0]          count;

  assign s = sync[SYNC_STAGES-1] ^ INVERT;

  // Pulses are combinational so the event flags in the top land on the
  // same edge as the clean level.
  assign accept     = (state == ST_PENDING) && (s != clean) && (count == CNT_MAX);
  assign rise_pulse = accept & s;
  assign fall_pulse = accept & ~s;

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      // Loading the idle pin level keeps reset release free of events.
      sync  <= {SYNC_STAGES{INVERT}};
      state <= ST_STABLE;
      count <= '0;
      clean <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (state == ST_STABLE) begin
        if (s != clean) begin
          state <= ST_PENDING;
          count <= CW'(1);
        end
      end else begin
        if (s == clean) begin
          state <= ST_STABLE;
          count <= '0;
        end else if (count == CNT_MAX) begin
          clean <= s;
          state <= ST_STABLE;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner
// Conditions board buttons/switches: per-bit debounce, sticky edge flags
// with write-1-to-clear, and a registered masked level interrupt.
// Ports:
//   clk_50     in   system clock, 50 MHz
//   reset      in   synchronous active-low reset
//   raw_in     in   asynchronous pins {pio_sw, pio_btn}
//   clean_out  out  debounced, polarity-normalised levels
//   rise_evt   out  sticky 0->1 flags
//   fall_evt   out  sticky 1->0 flags
//   evt_clear  in   write-1-to-clear for both flags of each bit
//   irq_mask   in   per-bit interrupt enable
//   irq        out  registered OR of masked flags
module pio_input_conditioner
  import pio_cond_pkg::*;
#(
  parameter int               WIDTH           = 13,
  parameter int               SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = 'h000F
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_evt,
  output logic [WIDTH-1:0] fall_evt,
  input  logic [WIDTH-1:0] evt_clear,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq
);

  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_bit (
      .clk_50     (clk_50),
      .reset      (reset),
      .raw        (raw_in[i]),
      .clean      (clean_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      rise_evt <= '0;
      fall_evt <= '0;
      irq      <= 1'b0;
    end else begin
      rise_evt <= (rise_evt & ~evt_clear) | rise_pulse;
      fall_evt <= (fall_evt & ~evt_clear) | fall_pulse;
      irq      <= |((rise_evt | fall_evt) & irq_mask);
    end
  end

endmodule

// File: doc/pio_input_conditioner.md
Name: pio_input_conditioner

Overview:
- Input-side counterpart to the 7-segment output path. It conditions the raw board buttons and switches (pio_btn, pio_sw) before they reach the platform PIO inputs.
- Per-bit processing: synchronise, debounce, normalise polarity, then detect edges into sticky event flags with write-1-to-clear semantics.
- A level interrupt is raised from the masked event flags.
- Sits between the board pins and the Nios platform, inside the top level.

Parameters:
- WIDTH, 13, number of conditioned inputs (4 buttons + 9 switches).
- SYNC_STAGES, 2, flip-flop depth of the metastability synchroniser; legal values 2..4.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a change (10 ms at 50 MHz); must be >= 1, checked by an elaboration-time assertion.
- INVERT_MASK, 13'h000F, per-bit inversion from raw pin to logical level. A 1 marks an active-low pin (the buttons).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- raw_in  in  WIDTH  asynchronous board pins ({pio_sw, pio_btn}).
- clean_out  out  WIDTH  debounced, polarity-normalised level (1 = pressed/on).
- rise_evt  out  WIDTH  sticky flag per bit: a 0->1 transition was accepted on clean_out.
- fall_evt  out  WIDTH  sticky flag per bit: a 1->0 transition was accepted on clean_out.
- evt_clear  in  WIDTH  write-1-to-clear strobe; clears both rise_evt and fall_evt of each selected bit.
- irq_mask  in  WIDTH  1 = the bit's events contribute to irq.
- irq  out  1  registered: OR over bits of (rise_evt | fall_evt) & irq_mask.

Behaviour:
- Reset (reset==0 at a clk_50 edge):
  - clean_out=0, rise_evt=0, fall_evt=0, irq=0.
  - Every synchroniser stage is loaded with INVERT_MASK, the idle raw level, so releasing reset never produces a spurious event.
  - Debounce counters are cleared and all per-bit FSMs go to STABLE.
- Synchroniser:
  - SYNC_STAGES flops per bit.
  - The synchroniser output s[i] is the final stage XOR INVERT_MASK[i].
- Per-bit FSM, with count width $clog2(DEBOUNCE_CYCLES+1):
  - STABLE: if s != clean_out, go to PENDING with count=1. Otherwise stay.
  - PENDING:
    - If s == clean_out, go to STABLE with count=0. This is bounce rejection; no event is produced.
    - Else if count == DEBOUNCE_CYCLES, then on this edge clean_out <= s, a one-cycle internal edge pulse is generated (rise if s==1, fall if s==0), and the FSM goes to STABLE.
    - Otherwise count++.
- Latency:
  - Required result: clean_out changes on the edge at which s has differed from clean_out for DEBOUNCE_CYCLES+1 consecutive sampled clocks.
  - Measured from the raw edge, that is SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks.
- Event flags, same clock as the edge pulse:
  - rise_evt[i] <= (rise_evt[i] & ~evt_clear[i]) | rise_pulse[i]. fall_evt uses the same rule with fall_pulse.
  - Set wins over a simultaneous clear.
  - Flags saturate; repeat events are not counted.
- irq:
  - Registered one cycle after the flags.
  - Drops one cycle after the clear that empties the last masked flag.
  - Changing irq_mask takes effect on irq on the next edge.
- Boundaries:
  - A glitch shorter than DEBOUNCE_CYCLES+1 clocks after the synchroniser never reaches clean_out.
  - A reset asserted mid-PENDING aborts the count. clean_out returns to 0 with no event generated.
  - Bits are fully independent; simultaneous changes on several bits produce simultaneous flags.
  - A counter at DEBOUNCE_CYCLES never wraps.

Decomposition:
- Package pio_cond_pkg holds:
  - typedef enum logic {ST_STABLE, ST_PENDING} deb_state_t;
  - localparam default values for a 50 MHz clock and a 10 ms debounce.
  - Function cnt_width(n), returning $clog2(n+1).
- Sub-module debounce_bit:
  - Contains the synchroniser, FSM and counter for one bit.
  - Outputs: clean, rise_pulse, fall_pulse.
  - Instantiated WIDTH times with a generate loop.
- The top module holds the event flags, clear logic and irq.

Test Plan:
- Default INVERT_MASK, bench overrides DEBOUNCE_CYCLES=4, SYNC_STAGES=2: hold reset low for 3 clocks with raw_in=13'h000F, then release -> clean_out=0, no flags, irq=0.
- Drive raw_in[0] 1->0 (button 0 pressed) and hold -> clean_out[0] rises exactly 7 clocks after the raw edge, with rise_evt[0]=1 on the same edge. With irq_mask=1, irq=1 one clock later.
- Toggle raw_in[5] high for 3 clocks then low, repeat 4 times -> clean_out[5] stays 0 and rise_evt[5]/fall_evt[5] stay 0.
- Set evt_clear[0]=1 on the same cycle a fall pulse for bit 0 occurs -> fall_evt[0]=1 (set wins) and rise_evt[0]=0.
- Set raw_in[12]=1 for 10 clocks, assert reset at clock 5 of the pending count -> after reset release, clean_out=0 and no events. Re-qualifying then takes the full 7 clocks.
- With irq_mask=13'h0001, generate an event on bit 3 -> irq stays 0. Set irq_mask[3]=1 -> irq=1 on the next edge. Pulse evt_clear=13'h0008 -> irq=0 one clock after the flag clears.
